// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline-stage specifiers and control bits in,
// stall/flush/forwarding controls and the multi-cycle busy status out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs_D;
    logic [4:0]       Rt_D;
    logic [4:0]       Rs_E;
    logic [4:0]       Rt_E;
    logic [4:0]       Write_Reg_E;
    logic [4:0]       Write_Reg_M;
    logic [4:0]       Write_Reg_W;
    logic             Reg_Write_E;
    logic             Reg_Write_M;
    logic             Reg_Write_W;
    logic             MemToReg_E;
    logic             MemToReg_M;
    logic             Branch_D;
    logic             Branch_Taken_D;
    logic             Jump_D;
    logic             HiLo_Use_D;
    logic             MC_Start_E;
    logic             Stall_F;
    logic             Stall_D;
    logic             Flush_D;
    logic             Flush_E;
    logic [1:0]       Forward_AE;
    logic [1:0]       Forward_BE;
    logic             Forward_AD;
    logic             Forward_BD;
    logic             MC_Busy;
    logic [CNT_W-1:0] Stall_Cycles;

    modport master (
        output Rs_D, Rt_D, Rs_E, Rt_E,
        output Write_Reg_E, Write_Reg_M, Write_Reg_W,
        output Reg_Write_E, Reg_Write_M, Reg_Write_W,
        output MemToReg_E, MemToReg_M,
        output Branch_D, Branch_Taken_D, Jump_D,
        output HiLo_Use_D, MC_Start_E,
        input  Stall_F, Stall_D, Flush_D, Flush_E,
        input  Forward_AE, Forward_BE, Forward_AD, Forward_BD,
        input  MC_Busy, Stall_Cycles
    );

    modport slave (
        input  Rs_D, Rt_D, Rs_E, Rt_E,
        input  Write_Reg_E, Write_Reg_M, Write_Reg_W,
        input  Reg_Write_E, Reg_Write_M, Reg_Write_W,
        input  MemToReg_E, MemToReg_M,
        input  Branch_D, Branch_Taken_D, Jump_D,
        input  HiLo_Use_D, MC_Start_E,
        output Stall_F, Stall_D, Flush_D, Flush_E,
        output Forward_AE, Forward_BE, Forward_AD, Forward_BD,
        output MC_Busy, Stall_Cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard controller: forwarding selects, load-use/branch/HI-LO
// stalls, redirect flushes, mult/div busy countdown and stall-cycle counter.
module hazard_ctrl #(
    parameter int MC_LAT = 32,
    parameter int CNT_W  = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] BUSY   = 1'b1;
    localparam logic [5:0] RELOAD = 6'(MC_LAT - 1);

    logic [0:0]       state;
    logic [5:0]       cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             lw_stall;
    logic             br_stall;
    logic             mc_stall;
    logic             stall;
    logic             e_hit_d;
    logic             m_hit_d;
    logic             wre_hit_d;

    // $0 never produces a dependency, so every match is qualified by a nonzero register
    assign wre_hit_d = (hz.Write_Reg_E != 5'd0) &&
                       (hz.Write_Reg_E == hz.Rs_D || hz.Write_Reg_E == hz.Rt_D);
    assign e_hit_d   = hz.Reg_Write_E && wre_hit_d;
    assign m_hit_d   = hz.MemToReg_M && (hz.Write_Reg_M != 5'd0) &&
                       (hz.Write_Reg_M == hz.Rs_D || hz.Write_Reg_M == hz.Rt_D);

    assign lw_stall = hz.MemToReg_E && wre_hit_d;
    assign br_stall = hz.Branch_D && (e_hit_d || m_hit_d);
    assign mc_stall = hz.HiLo_Use_D && (state == BUSY);
    assign stall    = lw_stall || br_stall || mc_stall;

    assign hz.Stall_F = stall;
    assign hz.Stall_D = stall;
    assign hz.Flush_E = stall;
    assign hz.Flush_D = (hz.Branch_Taken_D || hz.Jump_D) && !stall;
    assign hz.MC_Busy = (state == BUSY);
    assign hz.Stall_Cycles = stall_cnt;

    assign hz.Forward_AD = hz.Reg_Write_M && (hz.Rs_D != 5'd0) &&
                           (hz.Write_Reg_M == hz.Rs_D);
    assign hz.Forward_BD = hz.Reg_Write_M && (hz.Rt_D != 5'd0) &&
                           (hz.Write_Reg_M == hz.Rt_D);

    // M stage holds the younger result, so it takes priority over W
    always_comb begin
        hz.Forward_AE = 2'b00;
        if (hz.Rs_E != 5'd0) begin
            if (hz.Reg_Write_M && hz.Write_Reg_M == hz.Rs_E)
                hz.Forward_AE = 2'b10;
            else if (hz.Reg_Write_W && hz.Write_Reg_W == hz.Rs_E)
                hz.Forward_AE = 2'b01;
        end
    end

    always_comb begin
        hz.Forward_BE = 2'b00;
        if (hz.Rt_E != 5'd0) begin
            if (hz.Reg_Write_M && hz.Write_Reg_M == hz.Rt_E)
                hz.Forward_BE = 2'b10;
            else if (hz.Reg_Write_W && hz.Write_Reg_W == hz.Rt_E)
                hz.Forward_BE = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else if (hz.MC_Start_E) begin
            state <= BUSY;
            cnt   <= RELOAD;
        end else if (state == BUSY) begin
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1)
                state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MC_LAT=4 and a 3-bit stall counter
// so that saturation is reachable in a handful of cycles.
module tb_hazard_ctrl;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.Rs_D = 0; hz.Rt_D = 0; hz.Rs_E = 0; hz.Rt_E = 0;
        hz.Write_Reg_E = 0; hz.Write_Reg_M = 0; hz.Write_Reg_W = 0;
        hz.Reg_Write_E = 0; hz.Reg_Write_M = 0; hz.Reg_Write_W = 0;
        hz.MemToReg_E = 0; hz.MemToReg_M = 0;
        hz.Branch_D = 0; hz.Branch_Taken_D = 0; hz.Jump_D = 0;
        hz.HiLo_Use_D = 0; hz.MC_Start_E = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stallf"}, 32'(hz.Stall_F), 0);
        chk({tag, "_stalld"}, 32'(hz.Stall_D), 0);
        chk({tag, "_flushd"}, 32'(hz.Flush_D), 0);
        chk({tag, "_flushe"}, 32'(hz.Flush_E), 0);
        chk({tag, "_fae"}, 32'(hz.Forward_AE), 0);
        chk({tag, "_fbe"}, 32'(hz.Forward_BE), 0);
        chk({tag, "_fad"}, 32'(hz.Forward_AD), 0);
        chk({tag, "_fbd"}, 32'(hz.Forward_BD), 0);
        chk({tag, "_busy"}, 32'(hz.MC_Busy), 0);
        chk({tag, "_cnt"}, 32'(hz.Stall_Cycles), 0);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_quiet("reset");

        // forwarding priority M over W, and $0 on Rt_E
        hz.Reg_Write_M = 1; hz.Write_Reg_M = 5;
        hz.Reg_Write_W = 1; hz.Write_Reg_W = 5;
        hz.Rs_E = 5; hz.Rt_E = 0;
        #1;
        chk("fwd_ae_m", 32'(hz.Forward_AE), 2);
        chk("fwd_be_r0", 32'(hz.Forward_BE), 0);
        hz.Reg_Write_M = 0;
        #1;
        chk("fwd_ae_w", 32'(hz.Forward_AE), 1);
        hz.Rt_E = 5;
        #1;
        chk("fwd_be_w", 32'(hz.Forward_BE), 1);
        clr();

        hz.Reg_Write_M = 1; hz.Write_Reg_M = 7; hz.Rs_D = 7; hz.Rt_D = 9;
        #1;
        chk("fwd_ad", 32'(hz.Forward_AD), 1);
        chk("fwd_bd", 32'(hz.Forward_BD), 0);
        hz.Write_Reg_M = 0; hz.Rs_D = 0;
        #1;
        chk("fwd_ad_r0", 32'(hz.Forward_AD), 0);
        clr();

        // load-use stall for one cycle
        hz.MemToReg_E = 1; hz.Write_Reg_E = 8; hz.Rt_D = 8;
        #1;
        chk("lw_stallf", 32'(hz.Stall_F), 1);
        chk("lw_stalld", 32'(hz.Stall_D), 1);
        chk("lw_flushe", 32'(hz.Flush_E), 1);
        step();
        clr();
        #1;
        chk("lw_release", 32'(hz.Stall_D), 0);
        chk("lw_cnt", 32'(hz.Stall_Cycles), 1);
        hz.MemToReg_E = 1; hz.Write_Reg_E = 0; hz.Rt_D = 0;
        #1;
        chk("lw_r0", 32'(hz.Stall_D), 0);
        clr();

        // branch waits on E producer, then redirects
        hz.Branch_D = 1; hz.Rs_D = 3; hz.Reg_Write_E = 1;
        hz.Write_Reg_E = 3; hz.Branch_Taken_D = 1;
        #1;
        chk("br_stall", 32'(hz.Stall_D), 1);
        chk("br_noflush", 32'(hz.Flush_D), 0);
        step();
        hz.Reg_Write_E = 0; hz.Write_Reg_E = 0;
        #1;
        chk("br_go", 32'(hz.Stall_D), 0);
        chk("br_flush", 32'(hz.Flush_D), 1);
        chk("br_cnt", 32'(hz.Stall_Cycles), 2);
        clr();
        hz.Branch_D = 1; hz.Rt_D = 4; hz.MemToReg_M = 1; hz.Write_Reg_M = 4;
        #1;
        chk("br_m_load", 32'(hz.Stall_D), 1);
        clr();
        hz.Jump_D = 1;
        #1;
        chk("jmp_flush", 32'(hz.Flush_D), 1);
        clr();

        // mult/div: HiLo user stalls MC_LAT-1 cycles
        hz.MC_Start_E = 1;
        #1;
        chk("mc_idle", 32'(hz.MC_Busy), 0);
        step();
        hz.MC_Start_E = 0; hz.HiLo_Use_D = 1;
        for (int i = 0; i < MC_LAT - 1; i++) begin
            #1;
            chk($sformatf("mc_busy%0d", i), 32'(hz.MC_Busy), 1);
            chk($sformatf("mc_stall%0d", i), 32'(hz.Stall_D), 1);
            step();
        end
        chk("mc_done", 32'(hz.MC_Busy), 0);
        chk("mc_nostall", 32'(hz.Stall_D), 0);
        chk("mc_cnt", 32'(hz.Stall_Cycles), 5);
        clr();

        // reset during second busy cycle
        hz.MC_Start_E = 1;
        step();
        hz.MC_Start_E = 0;
        step();
        chk("rb_busy2", 32'(hz.MC_Busy), 1);
        clr();
        rst = 1'b1;
        step();
        chk("rb_busy", 32'(hz.MC_Busy), 0);
        chk("rb_cnt", 32'(hz.Stall_Cycles), 0);
        rst = 1'b0;
        #1;
        chk_quiet("rb");

        // saturation of the 3-bit stall counter
        hz.MemToReg_E = 1; hz.Write_Reg_E = 8; hz.Rt_D = 8;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("sat%0d", i), 32'(hz.Stall_Cycles),
                (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        chk("sat_stall", 32'(hz.Stall_D), 1);
        clr();
        step();
        chk("sat_hold", 32'(hz.Stall_Cycles), 7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
